// File: rtl/main_cmd_arbiter.sv
// Two-source command arbiter for main_core: round-robin single shots, per-source
// sequence locking with an idle watchdog, and a one-entry registered output stage.
module main_cmd_arbiter #(
  parameter int CMD_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] a_cmd,
  input  logic             a_hasAny,
  input  logic             a_last,
  output logic             a_consume,
  input  logic [CMD_W-1:0] b_cmd,
  input  logic             b_hasAny,
  input  logic             b_last,
  output logic             b_consume,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_hasAny,
  input  logic             cmd_consume,
  output logic             owner,
  output logic             owner_valid,
  output logic             err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic             lock_b;    // lock owner: 0=A, 1=B
  logic             rr_ptr;    // round-robin preference: 0=A, 1=B
  logic [CNT_W-1:0] idle_cnt;

  logic             slot_free;
  logic             sel_b;
  logic             sel_req;
  logic             sel_last;
  logic [CMD_W-1:0] sel_cmd;
  logic             grant;
  logic             lock_req;
  logic             expire;

  always_comb begin
    slot_free = !cmd_hasAny || cmd_consume;
    if (state == LOCKED) sel_b = lock_b;
    else                 sel_b = (b_hasAny && !a_hasAny) || (a_hasAny && b_hasAny && rr_ptr);
    sel_req   = sel_b ? b_hasAny : a_hasAny;
    sel_last  = sel_b ? b_last   : a_last;
    sel_cmd   = sel_b ? b_cmd    : a_cmd;
    // Gating with rst keeps the upstream handshakes quiet during reset.
    grant     = rst && slot_free && sel_req;
    a_consume = grant && !sel_b;
    b_consume = grant && sel_b;
    lock_req  = lock_b ? b_hasAny : a_hasAny;
    expire    = (state == LOCKED) && !lock_req && (idle_cnt == CNT_LAST);
  end

  assign owner_valid = cmd_hasAny || (state == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd         <= '0;
      cmd_hasAny  <= 1'b0;
      owner       <= 1'b0;
      err_timeout <= 1'b0;
      state       <= IDLE;
      lock_b      <= 1'b0;
      rr_ptr      <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      err_timeout <= expire;
      if (slot_free) begin
        cmd_hasAny <= grant;
        if (grant) begin
          cmd   <= sel_cmd;
          owner <= sel_b;
        end
      end
      case (state)
        IDLE: begin
          if (grant) begin
            if (sel_last) begin
              rr_ptr <= !sel_b;
            end else begin
              state    <= LOCKED;
              lock_b   <= sel_b;
              idle_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          // A transfer in the expiry cycle takes priority over the watchdog.
          if ((grant && sel_last) || expire) begin
            state    <= IDLE;
            rr_ptr   <= !lock_b;
            idle_cnt <= '0;
          end else if (lock_req) begin
            idle_cnt <= '0;
          end else if (idle_cnt != CNT_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_cmd_arbiter.sv
// Directed bench for main_cmd_arbiter: stimulus pushes expected {owner,cmd} into a
// queue, a negedge monitor pops and compares on every downstream transfer.
module tb_main_cmd_arbiter;
  localparam int CMD_W = 16;

  logic             clk;
  logic             rst;
  logic [CMD_W-1:0] a_cmd, b_cmd, cmd;
  logic             a_hasAny, a_last, a_consume;
  logic             b_hasAny, b_last, b_consume;
  logic             cmd_hasAny, cmd_consume;
  logic             owner, owner_valid, err_timeout;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  logic [CMD_W:0] exp_q[$];

  main_cmd_arbiter #(.CMD_W(CMD_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .a_cmd(a_cmd), .a_hasAny(a_hasAny), .a_last(a_last), .a_consume(a_consume),
    .b_cmd(b_cmd), .b_hasAny(b_hasAny), .b_last(b_last), .b_consume(b_consume),
    .cmd(cmd), .cmd_hasAny(cmd_hasAny), .cmd_consume(cmd_consume),
    .owner(owner), .owner_valid(owner_valid), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic own, input logic [CMD_W-1:0] c);
    exp_q.push_back({own, c});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream monitor
  initial begin
    logic [CMD_W:0] e;
    forever begin
      @(negedge clk);
      if (rst && err_timeout) err_pulses++;
      if (rst && cmd_hasAny && cmd_consume) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd: got %0h owner %0d with nothing expected", cmd, owner);
        end else begin
          e = exp_q.pop_front();
          if ({owner, cmd} !== e) begin
            errors++;
            $display("FAIL core_cmd: got owner %0d cmd %0h expected owner %0d cmd %0h",
                     owner, cmd, e[CMD_W], e[CMD_W-1:0]);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0; cmd_consume = 1'b0;
    a_cmd = '0; a_hasAny = 1'b0; a_last = 1'b0;
    b_cmd = '0; b_hasAny = 1'b0; b_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", cmd, 0);
    chk("rst_hasAny", cmd_hasAny, 0);
    chk("rst_owner_valid", owner_valid, 0);
    chk("rst_err", err_timeout, 0);
    tick();
    rst = 1'b1;

    // Round-robin single shots
    a_cmd = 16'h0A01; a_last = 1'b1; a_hasAny = 1'b1;
    b_cmd = 16'h0B01; b_last = 1'b1; b_hasAny = 1'b1;
    cmd_consume = 1'b1;
    repeat (3) begin push(1'b0, 16'h0A01); push(1'b1, 16'h0B01); end
    @(negedge clk);
    chk("rr_first_a_consume", a_consume, 1);
    chk("rr_first_b_consume", b_consume, 0);
    chk("rr_first_hasAny", cmd_hasAny, 0);
    tick();
    @(negedge clk);
    chk("rr_latency_hasAny", cmd_hasAny, 1);
    repeat (5) @(posedge clk);
    #1;
    a_hasAny = 1'b0; b_hasAny = 1'b0;
    tick();

    // Locked sequence from A with B waiting
    a_cmd = 16'h0A01; a_last = 1'b0; a_hasAny = 1'b1;
    b_cmd = 16'h0B01; b_last = 1'b1; b_hasAny = 1'b1;
    push(1'b0, 16'h0A01); push(1'b0, 16'h0A02); push(1'b0, 16'h0A03); push(1'b1, 16'h0B01);
    @(negedge clk);
    chk("lock_a_consume1", a_consume, 1);
    chk("lock_b_blocked1", b_consume, 0);
    tick();
    a_cmd = 16'h0A02;
    @(negedge clk);
    chk("lock_b_blocked2", b_consume, 0);
    chk("lock_owner", owner, 0);
    chk("lock_owner_valid", owner_valid, 1);
    tick();
    a_cmd = 16'h0A03; a_last = 1'b1;
    @(negedge clk);
    chk("lock_b_blocked3", b_consume, 0);
    chk("lock_a_consume3", a_consume, 1);
    tick();
    a_hasAny = 1'b0;
    @(negedge clk);
    chk("lock_b_after", b_consume, 1);
    chk("lock_owner_a03", owner, 0);
    tick();
    b_hasAny = 1'b0;
    tick();

    // Backpressure
    cmd_consume = 1'b0;
    a_cmd = 16'h0A01; a_last = 1'b1; a_hasAny = 1'b1;
    push(1'b0, 16'h0A01); push(1'b0, 16'h0A02);
    @(negedge clk);
    chk("bp_first_consume", a_consume, 1);
    tick();
    a_cmd = 16'h0A02;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_cmd_stable", cmd, 16'h0A01);
      chk("bp_hasAny", cmd_hasAny, 1);
      chk("bp_a_stalled", a_consume, 0);
      chk("bp_no_timeout", err_timeout, 0);
    end
    tick();
    cmd_consume = 1'b1;
    @(negedge clk);
    chk("bp_release_consume", a_consume, 1);
    tick();
    a_hasAny = 1'b0;
    tick();

    // Watchdog expiry: A locks then goes silent while B waits
    a_cmd = 16'h0A01; a_last = 1'b0; a_hasAny = 1'b1;
    push(1'b0, 16'h0A01); push(1'b1, 16'h0B01);
    @(negedge clk);
    chk("to_a_consume", a_consume, 1);
    tick();
    a_hasAny = 1'b0;
    b_cmd = 16'h0B01; b_last = 1'b1; b_hasAny = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("to_b_blocked", b_consume, 0);
      chk("to_err_early", err_timeout, 0);
      @(posedge clk);
    end
    #1;
    @(negedge clk);
    chk("to_err_pulse", err_timeout, 1);
    chk("to_b_consume", b_consume, 1);
    tick();
    b_hasAny = 1'b0;
    @(negedge clk);
    chk("to_err_one_cycle", err_timeout, 0);
    tick();

    // Source returns on the expiry cycle: no timeout
    a_cmd = 16'h0A02; a_last = 1'b0; a_hasAny = 1'b1;
    push(1'b0, 16'h0A02); push(1'b0, 16'h0A03);
    @(negedge clk);
    chk("nto_a_consume", a_consume, 1);
    tick();
    a_hasAny = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("nto_err_quiet", err_timeout, 0);
      @(posedge clk);
    end
    #1;
    a_cmd = 16'h0A03; a_last = 1'b1; a_hasAny = 1'b1;
    @(negedge clk);
    chk("nto_a_wins", a_consume, 1);
    chk("nto_err_expiry", err_timeout, 0);
    tick();
    a_hasAny = 1'b0;
    @(negedge clk);
    chk("nto_err_after", err_timeout, 0);
    tick();

    // Reset while LOCKED(B) with a command held
    cmd_consume = 1'b0;
    a_cmd = 16'h0A04; a_last = 1'b1; a_hasAny = 1'b1;
    b_cmd = 16'h0B02; b_last = 1'b0; b_hasAny = 1'b1;
    @(negedge clk);
    chk("rl_b_wins", b_consume, 1);
    chk("rl_a_loses", a_consume, 0);
    tick();
    b_hasAny = 1'b0;
    @(negedge clk);
    chk("rl_held", cmd_hasAny, 1);
    chk("rl_owner_b", owner, 1);
    chk("rl_owner_valid", owner_valid, 1);
    chk("rl_a_blocked", a_consume, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("rl_cmd_zero", cmd, 0);
    chk("rl_hasAny_zero", cmd_hasAny, 0);
    chk("rl_owner_zero", owner, 0);
    chk("rl_owner_valid_zero", owner_valid, 0);
    chk("rl_a_consume_zero", a_consume, 0);
    chk("rl_b_consume_zero", b_consume, 0);
    tick();
    rst = 1'b1;
    b_cmd = 16'h0B03; b_last = 1'b1; b_hasAny = 1'b1;
    cmd_consume = 1'b1;
    push(1'b0, 16'h0A04); push(1'b1, 16'h0B03);
    @(negedge clk);
    chk("rl_no_replay", cmd_hasAny, 0);
    chk("rl_a_first", a_consume, 1);
    chk("rl_b_second", b_consume, 0);
    tick();
    a_hasAny = 1'b0;
    @(negedge clk);
    chk("rl_b_next", b_consume, 1);
    tick();
    b_hasAny = 1'b0;
    tick();
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("err_pulse_count", err_pulses, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
